// File: rtl/echo_ranger.sv
// Ultrasonic echo ranger: times the sensor echo after a trigger pulse and reports
// the distance in centimetres, a near flag, and a no-echo timeout flag.
module echo_ranger #(
    parameter int WAIT_MAX_US = 1000,
    parameter int ECHO_MAX_US = 5800,
    parameter int US_PER_CM   = 58,
    parameter int MAX_CM      = 100,
    parameter int NEAR_CM     = 20
) (
    input  logic       clk_1m,
    input  logic       rst,
    input  logic       trig,
    input  logic       echo,
    output logic [6:0] distance,
    output logic       dist_valid,
    output logic       near,
    output logic       timeout
);

    localparam int WW = (WAIT_MAX_US > 1) ? $clog2(WAIT_MAX_US) : 1;
    localparam int UW = (ECHO_MAX_US > 1) ? $clog2(ECHO_MAX_US) : 1;
    localparam int SW = (US_PER_CM   > 1) ? $clog2(US_PER_CM)   : 1;

    localparam logic [WW-1:0] WAIT_LAST = WW'(WAIT_MAX_US - 1);
    localparam logic [UW-1:0] ECHO_LAST = UW'(ECHO_MAX_US - 1);
    localparam logic [SW-1:0] SUB_LAST  = SW'(US_PER_CM - 1);
    localparam logic [6:0]    MAX_V     = 7'(MAX_CM);
    localparam logic [6:0]    NEAR_V    = 7'(NEAR_CM);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_MEAS, S_DONE} state_t;

    state_t          r_state;
    logic            r_echo_m;
    logic            r_echo_s;
    logic            r_echo_d;
    logic            r_trig_d;
    logic [WW-1:0]   r_wait;
    logic [UW-1:0]   r_us;
    logic [SW-1:0]   r_sub;
    logic [6:0]      r_cm;
    logic [6:0]      r_distance;
    logic            r_valid;
    logic            r_near;
    logic            r_timeout;

    logic            w_trig_fall;
    logic            w_echo_rise;
    logic            w_echo_fall;
    logic            w_sub_wrap;
    logic [SW-1:0]   w_sub_next;
    logic [6:0]      w_cm_next;

    // Echo is asynchronous: two flops before any use, a third for edge detection.
    always_ff @(posedge clk_1m) begin
        if (!rst) begin
            r_echo_m <= 1'b0;
            r_echo_s <= 1'b0;
            r_echo_d <= 1'b0;
            r_trig_d <= 1'b0;
        end else begin
            r_echo_m <= echo;
            r_echo_s <= r_echo_m;
            r_echo_d <= r_echo_s;
            r_trig_d <= trig;
        end
    end

    assign w_trig_fall = r_trig_d & ~trig;
    assign w_echo_rise = r_echo_s & ~r_echo_d;
    assign w_echo_fall = ~r_echo_s & r_echo_d;

    // The cycle that sees the echo fall still counts, so N high cycles give N increments.
    assign w_sub_wrap = (r_sub == SUB_LAST);
    assign w_sub_next = w_sub_wrap ? '0 : r_sub + SW'(1);
    assign w_cm_next  = (w_sub_wrap && (r_cm != MAX_V)) ? r_cm + 7'd1 : r_cm;

    always_ff @(posedge clk_1m) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_wait     <= '0;
            r_us       <= '0;
            r_sub      <= '0;
            r_cm       <= '0;
            r_distance <= '0;
            r_valid    <= 1'b0;
            r_near     <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_trig_fall) begin
                        r_state <= S_WAIT;
                        r_wait  <= '0;
                    end
                end
                S_WAIT: begin
                    if (w_trig_fall) begin
                        r_wait <= '0;
                    end else if (w_echo_rise) begin
                        r_state <= S_MEAS;
                        r_us    <= '0;
                        r_sub   <= '0;
                        r_cm    <= '0;
                    end else if (r_wait == WAIT_LAST) begin
                        r_state    <= S_DONE;
                        r_distance <= MAX_V;
                        r_timeout  <= 1'b1;
                        r_near     <= 1'b0;
                        r_valid    <= 1'b1;
                    end else begin
                        r_wait <= r_wait + WW'(1);
                    end
                end
                S_MEAS: begin
                    if (w_trig_fall) begin
                        r_state <= S_WAIT;
                        r_wait  <= '0;
                        r_us    <= '0;
                        r_sub   <= '0;
                        r_cm    <= '0;
                    end else if (w_echo_fall) begin
                        r_state    <= S_DONE;
                        r_distance <= w_cm_next;
                        r_timeout  <= 1'b0;
                        r_near     <= (w_cm_next < NEAR_V);
                        r_valid    <= 1'b1;
                    end else if (r_us == ECHO_LAST) begin
                        r_state    <= S_DONE;
                        r_distance <= MAX_V;
                        r_timeout  <= 1'b0;
                        r_near     <= (MAX_V < NEAR_V);
                        r_valid    <= 1'b1;
                    end else begin
                        r_us  <= r_us + UW'(1);
                        r_sub <= w_sub_next;
                        r_cm  <= w_cm_next;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign distance   = r_distance;
    assign dist_valid = r_valid;
    assign near       = r_near;
    assign timeout    = r_timeout;

endmodule

// File: tb/tb_echo_ranger.sv
// Directed bench for echo_ranger: distance results, timeout, clamp, abort and reset
// behaviour, with expected values worked out by hand from the 58 us/cm scale.
`timescale 1ns/1ps
module tb_echo_ranger;

    logic       clk_1m = 1'b0;
    logic       rst;
    logic       trig;
    logic       echo;
    logic [6:0] distance;
    logic       dist_valid;
    logic       near;
    logic       timeout;

    int nvec = 0;
    int nerr = 0;
    int cyc = 0;
    int vcount = 0;
    int last_vcyc = 0;

    echo_ranger #(
        .WAIT_MAX_US(1000),
        .ECHO_MAX_US(5800),
        .US_PER_CM  (58),
        .MAX_CM     (100),
        .NEAR_CM    (20)
    ) dut (
        .clk_1m    (clk_1m),
        .rst       (rst),
        .trig      (trig),
        .echo      (echo),
        .distance  (distance),
        .dist_valid(dist_valid),
        .near      (near),
        .timeout   (timeout)
    );

    always #5 clk_1m = ~clk_1m;

    always @(posedge clk_1m) cyc <= cyc + 1;

    always @(negedge clk_1m) begin
        if (dist_valid) begin
            vcount    <= vcount + 1;
            last_vcyc <= cyc;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk_1m);
    endtask

    task automatic pulse_trig();
        trig = 1'b1;
        tick(10);
        trig = 1'b0;
    endtask

    task automatic echo_high(input int n, output int t_fall);
        echo = 1'b1;
        tick(n);
        echo   = 1'b0;
        t_fall = cyc;
    endtask

    task automatic test_reset();
        rst  = 1'b0;
        trig = 1'b0;
        echo = 1'b0;
        tick(4);
        nvec++; if (distance !== 7'd0) begin nerr++; $display("FAIL reset_distance got %0d want 0", distance); end
        nvec++; if (dist_valid !== 1'b0) begin nerr++; $display("FAIL reset_valid got %b want 0", dist_valid); end
        nvec++; if (near !== 1'b0) begin nerr++; $display("FAIL reset_near got %b want 0", near); end
        nvec++; if (timeout !== 1'b0) begin nerr++; $display("FAIL reset_timeout got %b want 0", timeout); end
        rst = 1'b1;
        tick(5);
    endtask

    task automatic test_dist20();
        int v0, tf;
        v0 = vcount;
        pulse_trig();
        tick(20);
        echo_high(1160, tf);
        tick(10);
        nvec++; if (vcount - v0 !== 1) begin nerr++; $display("FAIL d20_pulses got %0d want 1", vcount - v0); end
        nvec++; if (distance !== 7'd20) begin nerr++; $display("FAIL d20_distance got %0d want 20", distance); end
        nvec++; if (near !== 1'b0) begin nerr++; $display("FAIL d20_near got %b want 0", near); end
        nvec++; if (timeout !== 1'b0) begin nerr++; $display("FAIL d20_timeout got %b want 0", timeout); end
        nvec++; if (last_vcyc !== tf + 3) begin nerr++; $display("FAIL d20_latency got %0d want %0d", last_vcyc, tf + 3); end
        tick(10);
        nvec++; if (distance !== 7'd20) begin nerr++; $display("FAIL d20_hold got %0d want 20", distance); end
    endtask

    task automatic test_dist10_and_0();
        int v0, tf;
        v0 = vcount;
        pulse_trig();
        tick(15);
        echo_high(580, tf);
        tick(10);
        nvec++; if (vcount - v0 !== 1) begin nerr++; $display("FAIL d10_pulses got %0d want 1", vcount - v0); end
        nvec++; if (distance !== 7'd10) begin nerr++; $display("FAIL d10_distance got %0d want 10", distance); end
        nvec++; if (near !== 1'b1) begin nerr++; $display("FAIL d10_near got %b want 1", near); end
        v0 = vcount;
        pulse_trig();
        tick(15);
        echo_high(57, tf);
        tick(10);
        nvec++; if (vcount - v0 !== 1) begin nerr++; $display("FAIL d0_pulses got %0d want 1", vcount - v0); end
        nvec++; if (distance !== 7'd0) begin nerr++; $display("FAIL d0_distance got %0d want 0", distance); end
        nvec++; if (near !== 1'b1) begin nerr++; $display("FAIL d0_near got %b want 1", near); end
        v0 = vcount;
        pulse_trig();
        tick(15);
        echo_high(58, tf);
        tick(10);
        nvec++; if (distance !== 7'd1) begin nerr++; $display("FAIL d1_distance got %0d want 1", distance); end
    endtask

    task automatic test_timeout();
        int v0, t0;
        v0 = vcount;
        pulse_trig();
        t0 = cyc;
        tick(1010);
        nvec++; if (vcount - v0 !== 1) begin nerr++; $display("FAIL to_pulses got %0d want 1", vcount - v0); end
        nvec++; if (last_vcyc - t0 < 999 || last_vcyc - t0 > 1002) begin nerr++; $display("FAIL to_latency got %0d want 1000..1002", last_vcyc - t0); end
        nvec++; if (distance !== 7'd100) begin nerr++; $display("FAIL to_distance got %0d want 100", distance); end
        nvec++; if (timeout !== 1'b1) begin nerr++; $display("FAIL to_timeout got %b want 1", timeout); end
        nvec++; if (near !== 1'b0) begin nerr++; $display("FAIL to_near got %b want 0", near); end
    endtask

    task automatic test_clamp();
        int v0, a;
        v0 = vcount;
        pulse_trig();
        tick(20);
        echo = 1'b1;
        a = cyc;
        tick(7000);
        echo = 1'b0;
        tick(20);
        nvec++; if (vcount - v0 !== 1) begin nerr++; $display("FAIL clamp_pulses got %0d want 1", vcount - v0); end
        nvec++; if (last_vcyc - a < 5800 || last_vcyc - a > 5804) begin nerr++; $display("FAIL clamp_latency got %0d want 5800..5804", last_vcyc - a); end
        nvec++; if (distance !== 7'd100) begin nerr++; $display("FAIL clamp_distance got %0d want 100", distance); end
        nvec++; if (timeout !== 1'b0) begin nerr++; $display("FAIL clamp_timeout got %b want 0", timeout); end
    endtask

    task automatic test_abort();
        int v0, tf;
        v0 = vcount;
        echo = 1'b1;
        tick(100);
        echo = 1'b0;
        tick(20);
        nvec++; if (vcount !== v0) begin nerr++; $display("FAIL idle_echo_pulses got %0d want %0d", vcount, v0); end
        pulse_trig();
        tick(20);
        echo = 1'b1;
        tick(300);
        pulse_trig();
        tick(50);
        echo = 1'b0;
        tick(50);
        nvec++; if (vcount !== v0) begin nerr++; $display("FAIL abort_pulses got %0d want %0d", vcount, v0); end
        nvec++; if (distance !== 7'd100) begin nerr++; $display("FAIL abort_hold got %0d want 100", distance); end
        echo_high(1160, tf);
        tick(10);
        nvec++; if (vcount - v0 !== 1) begin nerr++; $display("FAIL abort_next_pulses got %0d want 1", vcount - v0); end
        nvec++; if (distance !== 7'd20) begin nerr++; $display("FAIL abort_next_distance got %0d want 20", distance); end
    endtask

    task automatic test_reset_meas();
        int v0, tf;
        pulse_trig();
        tick(15);
        echo_high(580, tf);
        tick(10);
        nvec++; if (near !== 1'b1) begin nerr++; $display("FAIL prereset_near got %b want 1", near); end
        pulse_trig();
        tick(5);
        echo = 1'b1;
        tick(300);
        rst = 1'b0;
        tick(1);
        rst = 1'b1;
        v0 = vcount;
        nvec++; if (distance !== 7'd0) begin nerr++; $display("FAIL rstmeas_distance got %0d want 0", distance); end
        nvec++; if (dist_valid !== 1'b0) begin nerr++; $display("FAIL rstmeas_valid got %b want 0", dist_valid); end
        nvec++; if (near !== 1'b0) begin nerr++; $display("FAIL rstmeas_near got %b want 0", near); end
        nvec++; if (timeout !== 1'b0) begin nerr++; $display("FAIL rstmeas_timeout got %b want 0", timeout); end
        tick(200);
        echo = 1'b0;
        tick(20);
        nvec++; if (vcount !== v0) begin nerr++; $display("FAIL rstmeas_pulses got %0d want %0d", vcount, v0); end
    endtask

    initial begin
        test_reset();
        test_dist20();
        test_dist10_and_0();
        test_timeout();
        test_clamp();
        test_abort();
        test_reset_meas();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/echo_ranger.md
ECHO_RANGER -- requirements
Module: echo_ranger

Interface
REQ-001 Parameter WAIT_MAX_US, 1000: max clk_1m cycles from trig falling edge to echo rise before a timeout.
REQ-002 Parameter ECHO_MAX_US, 5800: max echo-high cycles measured; longer echoes are clamped.
REQ-003 Parameter US_PER_CM, 58: echo-high cycles per centimetre of distance.
REQ-004 Parameter MAX_CM, 100: saturation value of distance; must fit 7 bits.
REQ-005 Parameter NEAR_CM, 20: near asserted when distance < NEAR_CM.
REQ-006 clk_1m  input  1  1 MHz system clock; sole clock, all logic on its rising edge.
REQ-007 rst  input  1  reset, synchronous, active-low.
REQ-008 trig  input  1  10 us sensor trigger from the trigger generator, same clock domain, not resynchronised.
REQ-009 echo  input  1  raw sensor echo, asynchronous to clk_1m.
REQ-010 distance  output  7  last measured distance in cm, registered.
REQ-011 dist_valid  output  1  one-cycle pulse, high when distance/near/timeout have just updated.
REQ-012 near  output  1  registered level, 1 when last result distance < NEAR_CM and timeout=0.
REQ-013 timeout  output  1  registered level, 1 when last cycle got no echo within WAIT_MAX_US.

Function
REQ-014 echo shall pass a 2-flop synchroniser (echo_s); edges are detected against a further registered copy of echo_s.
REQ-015 trig falling edge (trig_d=1, trig=0) shall be detected with one register on trig.
REQ-016 FSM states: IDLE, WAIT, MEAS, DONE; echo activity in IDLE is ignored.
REQ-017 IDLE -> WAIT on trig falling edge; wait counter cleared.
REQ-018 WAIT: wait counter increments each cycle; echo_s rising edge -> MEAS with sub counter and cm counter and us counter cleared.
REQ-019 WAIT: wait counter reaching WAIT_MAX_US-1 with no echo rise -> DONE with timeout result.
REQ-020 MEAS: us counter and sub counter increment each cycle; sub counter at US_PER_CM-1 wraps to 0 and cm counter +1, cm counter saturating at MAX_CM.
REQ-021 MEAS: echo_s falling edge -> DONE with result cm counter (distance = floor(high cycles / US_PER_CM)).
REQ-022 MEAS: us counter reaching ECHO_MAX_US-1 -> DONE with result MAX_CM, timeout=0; remaining echo high ignored (FSM in IDLE).
REQ-023 Timeout result: distance=MAX_CM, timeout=1, near=0.
REQ-024 distance, timeout, near shall update on the edge entering DONE; dist_valid high exactly for the single cycle in DONE; DONE -> IDLE unconditionally.
REQ-025 Latency: dist_valid rises on the 3rd clk_1m edge after the first edge sampling echo low.
REQ-026 trig falling edge while in WAIT or MEAS shall abort the measurement (no dist_valid, outputs hold) and re-enter WAIT with counters cleared.
REQ-027 Outputs hold last result between dist_valid pulses.
REQ-028 Counters shall be sized for their parameter maxima; no counter wraps past its limit.

Reset
REQ-029 rst=0 sampled on a clk_1m edge: state IDLE, all counters 0, synchroniser and edge registers 0, distance=0, dist_valid=0, near=0, timeout=0.
REQ-030 Reset mid-WAIT/MEAS discards the measurement; after release no dist_valid until a new trig falling edge and completed echo.

Verification
REQ-031 trig pulse, echo high 1160 cycles -> one dist_valid, distance=20, near=0, timeout=0.
REQ-032 trig pulse, echo high 580 cycles -> distance=10, near=1; echo high 57 cycles -> distance=0, near=1.
REQ-033 trig pulse, echo never rises -> dist_valid 1000 cycles after trig fall (+/-1), distance=100, timeout=1, near=0.
REQ-034 trig pulse, echo high 7000 cycles -> dist_valid after 5800 echo cycles, distance=100, timeout=0; no second pulse on echo fall.
REQ-035 echo pulse in IDLE, and second trig fall during MEAS -> no dist_valid for the aborted cycle; next echo of 1160 cycles gives distance=20.
REQ-036 rst=0 for one edge during MEAS -> all outputs 0 next cycle, no dist_valid on subsequent echo fall.
